// File: rtl/hazard_pkg.sv
`default_nettype none
// =============================================================================
// hazard_pkg : shared types/constants for the ID-stage hazard stall unit
// Rev 1.0
// =============================================================================
package hazard_pkg;

   localparam int REG_AW = 5;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hz_state_t;

   localparam int STALL_LOAD_BR  = 2;
   localparam int STALL_ALU_BR   = 1;
   localparam int STALL_LOAD_USE = 1;

   // Register $zero is hardwired, so it never carries a dependency.
   function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                      input logic [REG_AW-1:0] x);
      return (r != '0) && (r == x);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// =============================================================================
// hazard_stall_unit_if : pipeline-side signals of the hazard stall unit
// Optional HAZARD_STATS_EN adds StallCount/FlushCount.   Rev 1.0
// =============================================================================
interface hazard_stall_unit_if;
   import hazard_pkg::*;

   logic [REG_AW-1:0] RS_ID;
   logic [REG_AW-1:0] RT_ID;
   logic              UsesRT_ID;
   logic              Branch_ID;
   logic              Taken_ID;
   logic [REG_AW-1:0] RD_EX;
   logic              RegWrite_EX;
   logic              MemRead_EX;
   logic [REG_AW-1:0] RD_MEM;
   logic              MemRead_MEM;
   logic              ExtStall;
   logic              PCWrite;
   logic              IFIDWrite;
   logic              Bubble_ID;
   logic              Flush_IF;
   logic              Busy;
`ifdef HAZARD_STATS_EN
   logic [31:0]       StallCount;
   logic [31:0]       FlushCount;
`endif

   modport master (
      output RS_ID, RT_ID, UsesRT_ID, Branch_ID, Taken_ID,
      output RD_EX, RegWrite_EX, MemRead_EX, RD_MEM, MemRead_MEM, ExtStall,
`ifdef HAZARD_STATS_EN
      input  StallCount, FlushCount,
`endif
      input  PCWrite, IFIDWrite, Bubble_ID, Flush_IF, Busy
   );

   modport slave (
      input  RS_ID, RT_ID, UsesRT_ID, Branch_ID, Taken_ID,
      input  RD_EX, RegWrite_EX, MemRead_EX, RD_MEM, MemRead_MEM, ExtStall,
`ifdef HAZARD_STATS_EN
      output StallCount, FlushCount,
`endif
      output PCWrite, IFIDWrite, Bubble_ID, Flush_IF, Busy
   );

endinterface
`default_nettype wire

// File: rtl/hazard_stats_counter.sv
`default_nettype none
// =============================================================================
// hazard_stats_counter : 32-bit saturating event counter (HAZARD_STATS_EN only)
// Rev 1.0
// =============================================================================
`ifdef HAZARD_STATS_EN
module hazard_stats_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// =============================================================================
// hazard_stall_unit : ID-stage load-use / branch-operand stall sequencer
// Optional macro HAZARD_STATS_EN adds stall/flush event counters.   Rev 1.0
// =============================================================================
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int MAX_STALL = 2
) (
   input  logic               Clk,
   input  logic               Rst,
   hazard_stall_unit_if.slave hz
);

   localparam int CNT_W = $clog2(MAX_STALL + 1);

   hz_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_len;
   logic             w_hit_ex;
   logic             w_hit_mem;
   logic             w_stall;
   logic             w_pcwrite;
   logic             w_ifidwrite;
   logic             w_bubble;
   logic             w_flush;

   assign w_hit_ex  = reg_match(hz.RD_EX, hz.RS_ID) ||
                      (hz.UsesRT_ID && reg_match(hz.RD_EX, hz.RT_ID));
   assign w_hit_mem = reg_match(hz.RD_MEM, hz.RS_ID) ||
                      (hz.UsesRT_ID && reg_match(hz.RD_MEM, hz.RT_ID));

   // Longest applicable stall wins; ID-resolved branches need operands a stage earlier.
   always_comb begin
      w_len = '0;
      if (hz.Branch_ID && hz.MemRead_EX && w_hit_ex)
         w_len = CNT_W'(STALL_LOAD_BR);
      else if (!hz.Branch_ID && hz.MemRead_EX && w_hit_ex)
         w_len = CNT_W'(STALL_LOAD_USE);
      else if (hz.Branch_ID && hz.RegWrite_EX && !hz.MemRead_EX && w_hit_ex)
         w_len = CNT_W'(STALL_ALU_BR);
      else if (hz.Branch_ID && hz.MemRead_MEM && w_hit_mem)
         w_len = CNT_W'(STALL_ALU_BR);
   end

   assign w_stall = (r_state == HOLD) || (w_len != '0);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else if (!hz.ExtStall) begin
         case (r_state)
            RUN: begin
               if (w_len > CNT_W'(1)) begin
                  r_state <= HOLD;
                  r_cnt   <= w_len - CNT_W'(1);
               end
            end
            HOLD: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1))
                  r_state <= RUN;
            end
            default: begin
               r_state <= RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Reset dominates, then the external freeze, then hazard stalls.
   always_comb begin
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
      w_bubble    = 1'b0;
      w_flush     = 1'b0;
      if (Rst) begin
         w_bubble = 1'b1;
         w_flush  = 1'b1;
      end else if (!hz.ExtStall) begin
         w_pcwrite   = !w_stall;
         w_ifidwrite = !w_stall;
         w_bubble    = w_stall;
         w_flush     = hz.Taken_ID && hz.Branch_ID && !w_stall;
      end
   end

   assign hz.PCWrite   = w_pcwrite;
   assign hz.IFIDWrite = w_ifidwrite;
   assign hz.Bubble_ID = w_bubble;
   assign hz.Flush_IF  = w_flush;
   assign hz.Busy      = !Rst && (r_state == HOLD);

`ifdef HAZARD_STATS_EN
   hazard_stats_counter u_stall_cnt (
      .clk   (Clk),
      .rst   (Rst),
      .inc   (w_bubble),
      .count (hz.StallCount)
   );

   hazard_stats_counter u_flush_cnt (
      .clk   (Clk),
      .rst   (Rst),
      .inc   (w_flush),
      .count (hz.FlushCount)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// =============================================================================
// tb_hazard_stall_unit : directed self-checking bench for hazard_stall_unit
// Rev 1.0
// =============================================================================
module tb_hazard_stall_unit;

   logic Clk;
   logic Rst;
   int   checks;
   int   failures;

   hazard_stall_unit_if hz ();

   hazard_stall_unit #(.MAX_STALL(2)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .hz  (hz)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      hz.RS_ID       = '0;
      hz.RT_ID       = '0;
      hz.UsesRT_ID   = 1'b0;
      hz.Branch_ID   = 1'b0;
      hz.Taken_ID    = 1'b0;
      hz.RD_EX       = '0;
      hz.RegWrite_EX = 1'b0;
      hz.MemRead_EX  = 1'b0;
      hz.RD_MEM      = '0;
      hz.MemRead_MEM = 1'b0;
      hz.ExtStall    = 1'b0;
   endtask

   task automatic advance();
      @(posedge Clk);
      #1;
   endtask

   // exp = {PCWrite, IFIDWrite, Bubble_ID, Flush_IF, Busy}
   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      #2;
      obs = {hz.PCWrite, hz.IFIDWrite, hz.Bubble_ID, hz.Flush_IF, hz.Busy};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

`ifdef HAZARD_STATS_EN
   task automatic chk_stats(input string tag, input logic [31:0] es, input logic [31:0] ef);
      checks++;
      assert ((hz.StallCount === es) && (hz.FlushCount === ef)) else begin
         failures++;
         $error("FAIL %s observed=%0d/%0d expected=%0d/%0d", tag,
                hz.StallCount, hz.FlushCount, es, ef);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      Rst      = 1'b1;
      idle();

      chk("reset_outputs", 5'b00110);
      advance();
      chk("reset_outputs_2", 5'b00110);
      advance();
      Rst = 1'b0;
      chk("idle_after_reset", 5'b11000);
`ifdef HAZARD_STATS_EN
      chk_stats("stats_after_reset", 32'd0, 32'd0);
`endif
      advance();

      // lw $2 in EX, add $3,$2,$4 in ID
      hz.RD_EX = 5'd2; hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1;
      hz.RS_ID = 5'd2; hz.RT_ID = 5'd4; hz.UsesRT_ID = 1'b1;
      chk("load_use_stall", 5'b00100);
      advance();
      idle();
      hz.RD_MEM = 5'd2; hz.MemRead_MEM = 1'b1;
      hz.RS_ID = 5'd2; hz.RT_ID = 5'd4; hz.UsesRT_ID = 1'b1;
      chk("load_use_release", 5'b11000);
      advance();

      // lw $5 in EX, beq $5,$6 in ID
      idle();
      hz.RD_EX = 5'd5; hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1;
      hz.RS_ID = 5'd5; hz.RT_ID = 5'd6; hz.UsesRT_ID = 1'b1; hz.Branch_ID = 1'b1;
      chk("load_branch_cyc1", 5'b00100);
      advance();
      hz.RD_EX = '0; hz.MemRead_EX = 1'b0; hz.RegWrite_EX = 1'b0;
      hz.RD_MEM = 5'd5; hz.MemRead_MEM = 1'b1; hz.Taken_ID = 1'b1;
      chk("load_branch_cyc2_hold", 5'b00101);
      advance();
      hz.RD_MEM = '0; hz.MemRead_MEM = 1'b0;
      chk("load_branch_cyc3_flush", 5'b11010);
      advance();

      // add $7 in EX, bne $0,$7 in ID
      idle();
      hz.RD_EX = 5'd7; hz.RegWrite_EX = 1'b1;
      hz.RS_ID = 5'd0; hz.RT_ID = 5'd7; hz.UsesRT_ID = 1'b1; hz.Branch_ID = 1'b1;
      chk("alu_branch_stall", 5'b00100);
      advance();
      hz.RD_EX = '0; hz.RegWrite_EX = 1'b0; hz.RD_MEM = 5'd7;
      chk("alu_branch_release", 5'b11000);
      advance();

      idle();
      hz.RD_EX = 5'd0; hz.RegWrite_EX = 1'b1; hz.MemRead_EX = 1'b1;
      hz.RS_ID = 5'd0; hz.Branch_ID = 1'b1;
      chk("zero_reg_no_stall", 5'b11000);
      advance();

      idle();
      hz.RD_EX = 5'd9; hz.RegWrite_EX = 1'b1; hz.RS_ID = 5'd9;
      chk("alu_nonbranch_forwarded", 5'b11000);
      advance();
      hz.Branch_ID = 1'b1; hz.RegWrite_EX = 1'b0;
      chk("branch_ex_no_regwrite", 5'b11000);
      advance();

      // sw $8 with lw $8 in EX
      idle();
      hz.RD_EX = 5'd8; hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1;
      hz.RS_ID = 5'd9; hz.RT_ID = 5'd8; hz.UsesRT_ID = 1'b1;
      chk("sw_rt_stall", 5'b00100);
      advance();
      hz.UsesRT_ID = 1'b0;
      chk("sw_rt_unused_no_stall", 5'b11000);
      advance();

      // branch on a load now in MEM: one stall, taken flush suppressed
      idle();
      hz.RD_MEM = 5'd3; hz.MemRead_MEM = 1'b1;
      hz.RS_ID = 5'd3; hz.Branch_ID = 1'b1; hz.Taken_ID = 1'b1;
      chk("mem_load_branch_stall", 5'b00100);
      advance();
      idle();
      chk("mem_load_branch_release", 5'b11000);
      advance();

      // ExtStall raised during HOLD
      hz.RD_EX = 5'd5; hz.MemRead_EX = 1'b1; hz.RS_ID = 5'd5; hz.Branch_ID = 1'b1;
      chk("ext_setup_stall", 5'b00100);
      advance();
      idle();
      hz.ExtStall = 1'b1; hz.Branch_ID = 1'b1; hz.Taken_ID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ext_freeze_%0d", i), 5'b00001);
         advance();
      end
      hz.ExtStall = 1'b0;
      chk("ext_hold_resume", 5'b00101);
      advance();
      idle();
      chk("ext_back_to_run", 5'b11000);
      advance();

      // ExtStall overrides a fresh hazard in RUN
      hz.RD_EX = 5'd2; hz.MemRead_EX = 1'b1; hz.RS_ID = 5'd2; hz.ExtStall = 1'b1;
      chk("ext_over_hazard", 5'b00000);
      advance();
      hz.ExtStall = 1'b0;
      chk("hazard_after_ext", 5'b00100);
      advance();
      idle();
`ifdef HAZARD_STATS_EN
      chk_stats("stats_accumulated", 32'd9, 32'd1);
`endif

      // Rst pulsed during HOLD
      hz.RD_EX = 5'd5; hz.MemRead_EX = 1'b1; hz.RS_ID = 5'd5; hz.Branch_ID = 1'b1;
      chk("rst_setup_stall", 5'b00100);
      advance();
      Rst = 1'b1;
      chk("rst_in_hold", 5'b00110);
      advance();
      Rst = 1'b0;
      idle();
      chk("run_after_hold_reset", 5'b11000);
`ifdef HAZARD_STATS_EN
      chk_stats("stats_cleared", 32'd0, 32'd0);
`endif
      advance();
      hz.RD_EX = 5'd2; hz.MemRead_EX = 1'b1; hz.RS_ID = 5'd2;
      chk("load_use_after_reset", 5'b00100);
      advance();
      idle();
`ifdef HAZARD_STATS_EN
      chk_stats("stats_one_stall", 32'd1, 32'd0);
`endif
      chk("final_idle", 5'b11000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
